piso_mlane: RTL

- Single-clock, parametrised parallel-in/serial-out converter with internal word buffer.
- Accepts WIDTH-bit words on a valid/ready input port and stores them in a DEPTH-entry circular FIFO.
- Emits each word as WIDTH/LANES consecutive LANES-bit beats on a valid/ready serial port, with selectable bit order and a last-beat marker.
- Successor to the dual-clock PISO, for same-domain serial links: multi-lane, backpressure-safe, back-to-back words with no bubble.

---
 rtl/piso_mlane_if.sv | 33 +++
 rtl/piso_mlane.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/piso_mlane_if.sv
// ============================================================================
// piso_mlane_if : parallel-in / serial-out handshake bundle (word side + lane side)
// Rev 1.0
// ============================================================================
`default_nettype none

interface piso_mlane_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LANES = 1
);
  logic [WIDTH-1:0]           d_i;
  logic                       valid_i;
  logic                       ready_o;
  logic [LANES-1:0]           d_o;
  logic                       valid_o;
  logic                       last_o;
  logic                       ready_i;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic                       busy_o;

  modport slave (
    input  d_i, valid_i, ready_i,
    output ready_o, d_o, valid_o, last_o, count_o, busy_o
  );

  modport master (
    output d_i, valid_i, ready_i,
    input  ready_o, d_o, valid_o, last_o, count_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/piso_mlane.sv
// ============================================================================
// piso_mlane : single-clock FIFO-buffered PISO, LANES bits per beat, no inter-word bubble
// Rev 1.0
// ============================================================================
`default_nettype none

module piso_mlane #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  wire logic    clk,
  input  wire logic    rst_i,
  piso_mlane_if.slave  bus
);

  localparam int N_BEATS = WIDTH / LANES;
  localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N_BEATS - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             last_q, last_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             ready;
  logic             push;
  logic             pop;
  logic             xfer;
  logic             at_last;
  logic [BW-1:0]    beat_inc;
  logic [WIDTH-1:0] shift_nxt;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign ready    = !rst_i && (count_q != FULL_CNT);
  assign push     = bus.valid_i && ready;
  assign xfer     = (state_q == SHIFT) && bus.ready_i;
  assign at_last  = (beat_q == LAST_BEAT);
  assign beat_inc = beat_q + 1'b1;
  assign pop      = (count_q != '0) && ((state_q == IDLE) || (xfer && at_last));

  // The current beat always sits at the output end of shift_q.
  generate
    if (N_BEATS == 1) begin : g_single_beat
      assign shift_nxt = '0;
      assign bus.d_o   = shift_q;
    end else if (MSB_FIRST) begin : g_msb_first
      assign shift_nxt = {shift_q[WIDTH-LANES-1:0], {LANES{1'b0}}};
      assign bus.d_o   = shift_q[WIDTH-1 -: LANES];
    end else begin : g_lsb_first
      assign shift_nxt = {{LANES{1'b0}}, shift_q[WIDTH-1:LANES]};
      assign bus.d_o   = shift_q[LANES-1:0];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    shift_d  = shift_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      state_d  = SHIFT;
      beat_d   = '0;
      shift_d  = mem[rd_ptr_q];
      last_d   = (N_BEATS == 1);
    end else if (xfer) begin
      shift_d = shift_nxt;
      if (at_last) begin
        state_d = IDLE;
        beat_d  = '0;
        last_d  = 1'b0;
      end else begin
        beat_d = beat_inc;
        last_d = (beat_inc == LAST_BEAT);
      end
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      shift_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
    end
  end

  // Storage carries no reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.d_i;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = (state_q == SHIFT);
  assign bus.busy_o  = (state_q == SHIFT);
  assign bus.last_o  = last_q;
  assign bus.count_o = count_q;

endmodule

`default_nettype wire
